// File: rtl/q_inv_table.sv
// q_inv_table: inverse Twofish q0/q1 permutation table, built once after reset
// by sweeping the forward q, then serving one byte lookup per cycle.
module q_inv_table #(
    parameter int Q = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       init_done,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data
);
    // nibble tables packed with entry 0 in the top nibble
    localparam logic [63:0] T0 = (Q == 1) ? 64'h28BDF76E31940AC5 : 64'h817D6F320B59ECA4;
    localparam logic [63:0] T1 = (Q == 1) ? 64'h1E2B4C376DA5F908 : 64'hECB81235F4A6709D;
    localparam logic [63:0] T2 = (Q == 1) ? 64'h4C75169A0ED82B3F : 64'hBA5E6D90C8F32471;
    localparam logic [63:0] T3 = (Q == 1) ? 64'hB951C3DE647F208A : 64'hD7F4126E9B3085CA;

    typedef enum logic {INIT, READY} state_t;

    state_t     state, state_n;
    logic [7:0] cnt;
    logic [7:0] qx;
    logic [3:0] a1, b1, a2, b2, a3, b3, a4, b4;
    logic       accept;
    logic [7:0] inv [0:255];

    function automatic logic [3:0] lk(input logic [63:0] t, input logic [3:0] i);
        return t[{~i, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] ror4(input logic [3:0] b);
        return {b[0], b[3:1]};
    endfunction

    always_comb begin
        a1 = cnt[7:4] ^ cnt[3:0];
        b1 = cnt[7:4] ^ ror4(cnt[3:0]) ^ {cnt[4], 3'b000};
        a2 = lk(T0, a1);
        b2 = lk(T1, b1);
        a3 = a2 ^ b2;
        b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
        a4 = lk(T2, a3);
        b4 = lk(T3, b3);
        qx = {b4, a4};
    end

    always_comb begin
        state_n   = (state == INIT && cnt == 8'hFF) ? READY : state;
        init_done = (state == READY);
        req_ready = init_done && (!resp_valid || resp_ready);
        accept    = req_valid && req_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= (state == INIT) ? cnt + 8'd1 : cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) inv[qx] <= cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= inv[req_data];
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_q_inv_table.sv
// tb_q_inv_table: scoreboard bench running a q0 and a q1 instance side by side.
module tb_q_inv_table;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] init_done, req_valid, req_ready, resp_valid, resp_ready;
    logic [7:0] req_data [2];
    logic [7:0] resp_data [2];
    logic [7:0] exp_next [2];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    int         rc [2];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    q_inv_table #(.Q(0)) u0 (
        .clk(clk), .rst(rst), .init_done(init_done[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_data(req_data[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0])
    );
    q_inv_table #(.Q(1)) u1 (
        .clk(clk), .rst(rst), .init_done(init_done[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_data(req_data[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nib(input int qs, input int t, input logic [3:0] i);
        logic [63:0] tb;
        case (qs * 4 + t)
            0: tb = 64'h817D6F320B59ECA4;
            1: tb = 64'hECB81235F4A6709D;
            2: tb = 64'hBA5E6D90C8F32471;
            3: tb = 64'hD7F4126E9B3085CA;
            4: tb = 64'h28BDF76E31940AC5;
            5: tb = 64'h1E2B4C376DA5F908;
            6: tb = 64'h4C75169A0ED82B3F;
            default: tb = 64'hB951C3DE647F208A;
        endcase
        return tb[63 - 4 * int'(i) -: 4];
    endfunction

    function automatic logic [7:0] qf(input int qs, input logic [7:0] x);
        logic [3:0] a, b, na, nb;
        a = x[7:4];
        b = x[3:0];
        for (int r = 0; r < 2; r++) begin
            na = a ^ b;
            nb = a ^ {b[0], b[3:1]} ^ (a[0] ? 4'h8 : 4'h0);
            a = nib(qs, 2 * r, na);
            b = nib(qs, 2 * r + 1, nb);
        end
        return {b, a};
    endfunction

    always @(negedge clk) begin
        if (resp_valid[0] && resp_ready[0]) begin
            if (sb0.size() == 0) chk("sb0_underflow", 1, 0);
            else chk("resp_q0", 32'(resp_data[0]), 32'(sb0.pop_front()));
            rc[0]++;
        end
        if (req_valid[0] && req_ready[0]) sb0.push_back(exp_next[0]);
        if (resp_valid[1] && resp_ready[1]) begin
            if (sb1.size() == 0) chk("sb1_underflow", 1, 0);
            else chk("resp_q1", 32'(resp_data[1]), 32'(sb1.pop_front()));
            rc[1]++;
        end
        if (req_valid[1] && req_ready[1]) sb1.push_back(exp_next[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_init_done"}, 32'(init_done[k]), 0);
            chk({tag, "_resp_valid"}, 32'(resp_valid[k]), 0);
            chk({tag, "_resp_data"}, 32'(resp_data[k]), 0);
            chk({tag, "_req_ready"}, 32'(req_ready[k]), 0);
        end
    endtask

    task automatic build_wait(input string tag);
        int n = 0;
        int viol = 0;
        req_valid = 2'b11;
        while (n < 400 && init_done != 2'b11) begin
            req_data[0] = 8'($urandom);
            req_data[1] = 8'($urandom);
            step();
            n++;
            if (init_done == 2'b00 && (req_ready != 2'b00 || resp_valid != 2'b00)) viol++;
        end
        req_valid = 2'b00;
        chk({tag, "_edges"}, n, 256);
        chk({tag, "_quiet"}, viol, 0);
    endtask

    task automatic req(input int k, input logic [7:0] y, input logic [7:0] x);
        req_valid[k] = 1'b1;
        req_data[k]  = y;
        exp_next[k]  = x;
        step();
        req_valid[k] = 1'b0;
    endtask

    initial begin
        logic [7:0] held;
        int stalls;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        req_data   = '{8'h00, 8'h00};
        exp_next   = '{8'h00, 8'h00};
        rc         = '{0, 0};
        step();
        step();
        rst_chk("reset");
        rst = 1'b0;
        build_wait("build1");

        req_valid[0] = 1'b1; req_data[0] = 8'hA9; exp_next[0] = 8'h00;
        req_valid[1] = 1'b1; req_data[1] = 8'h75; exp_next[1] = 8'h00;
        step();
        req_data[0] = 8'h67; exp_next[0] = 8'h01;
        req_data[1] = 8'hF3; exp_next[1] = 8'h01;
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("known_cnt0", rc[0], 2);
        chk("known_cnt1", rc[1], 2);

        rc = '{0, 0};
        stalls = 0;
        req_valid = 2'b11;
        for (int x = 0; x < 256; x++) begin
            req_data[0] = qf(0, 8'(x)); exp_next[0] = 8'(x);
            req_data[1] = qf(1, 8'(x)); exp_next[1] = 8'(x);
            if (req_ready != 2'b11) stalls++;
            step();
        end
        req_valid = 2'b00;
        step();
        chk("tput_stalls", stalls, 0);
        chk("tput_cnt0", rc[0], 256);
        chk("tput_cnt1", rc[1], 256);

        req(0, qf(0, 8'd5), 8'd5);
        resp_ready[0] = 1'b0;
        held = resp_data[0];
        chk("bp_data", 32'(held), 5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", 32'(resp_data[0]), 32'(held));
            chk("bp_valid", 32'(resp_valid[0]), 1);
            chk("bp_ready", 32'(req_ready[0]), 0);
        end
        resp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_data[0] = qf(0, 8'd77); exp_next[0] = 8'd77;
        #1 chk("bp_release_ready", 32'(req_ready[0]), 1);
        step();
        req_valid[0] = 1'b0;
        step();
        step();

        rst = 1'b1;
        #1 rst_chk("rst_idle");
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        #1 rst_chk("rst_midbuild");
        step();
        rst = 1'b0;
        build_wait("build2");

        resp_ready[1] = 1'b0;
        req(1, qf(1, 8'd200), 8'd200);
        step();
        chk("stall_valid", 32'(resp_valid[1]), 1);
        rst = 1'b1;
        #1 rst_chk("rst_midstall");
        sb0.delete();
        sb1.delete();
        resp_ready[1] = 1'b1;
        step();
        rst = 1'b0;
        build_wait("build3");

        rc = '{0, 0};
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x0, x1;
            x0 = 8'($urandom);
            x1 = 8'($urandom);
            req_valid = 2'($urandom_range(1, 3));
            resp_ready = 2'($urandom_range(0, 3));
            req_data[0] = qf(0, x0); exp_next[0] = x0;
            req_data[1] = qf(1, x1); exp_next[1] = x1;
            step();
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        step();
        step();
        chk("drain0", sb0.size(), 0);
        chk("drain1", sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
